// File: rtl/mac_pkg.sv
// Shared constants, clamp helper and default lane-vector type for the mac_vec engine.
package mac_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int LANES_DEF  = 4;
    // Wide enough for a full product of two 64-bit operands
    localparam int WIDE_W     = 128;

    localparam logic signed [DATA_W_DEF-1:0] MIN_VAL = {1'b1, {(DATA_W_DEF-1){1'b0}}};
    localparam logic signed [DATA_W_DEF-1:0] MAX_VAL = {1'b0, {(DATA_W_DEF-1){1'b1}}};

    typedef logic signed [WIDE_W-1:0] wide_t;
    typedef logic [LANES_DEF-1:0][DATA_W_DEF-1:0] lane_vec_t;

    function automatic wide_t lim_max(input int width);
        return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t lim_min(input int width);
        return -(wide_t'(1) <<< (width - 1));
    endfunction

    function automatic wide_t sat(input wide_t value, input int width);
        wide_t r;
        r = value;
        if (value > lim_max(width)) r = lim_max(width);
        else if (value < lim_min(width)) r = lim_min(width);
        return r;
    endfunction
endpackage

// File: rtl/mac_vec_if.sv
// Input beat and result vector handshakes of mac_vec.
interface mac_vec_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32
);
    logic                           in_valid;
    logic                           in_ready;
    logic [LANES-1:0][DATA_W-1:0]   in_x;
    logic [LANES-1:0][DATA_W-1:0]   in_f;
    logic                           out_valid;
    logic                           out_ready;
    logic [LANES-1:0][DATA_W-1:0]   out_data;
    logic [LANES-1:0]               out_sat;

    modport master (
        output in_valid, in_x, in_f, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_x, in_f, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mac_lane.sv
// One lane: saturating multiply stage, saturating accumulate stage, sticky clamp flag
// and the held result register.
module mac_lane
    import mac_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    input  logic              beat,
    input  logic              m_vld,
    input  logic              m_first,
    input  logic              m_last,
    input  logic              m_relu,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] res,
    output logic              res_sat
);
    logic signed [2*DATA_W-1:0] p_full;
    wide_t                      p_wide;
    wide_t                      s_raw;
    wide_t                      s_wide;
    logic [DATA_W-1:0]          base;
    logic [DATA_W-1:0]          prod_d, prod_q;
    logic [DATA_W-1:0]          acc_d, acc_q;
    logic [DATA_W-1:0]          res_d, res_q;
    logic                       pclamp_d, pclamp_q;
    logic                       sclamp;
    logic                       flag_d, flag_q;
    logic                       res_sat_q;

    always_comb begin
        p_full   = (2*DATA_W)'($signed(x)) * (2*DATA_W)'($signed(f));
        p_wide   = sat(wide_t'(p_full), DATA_W);
        prod_d   = p_wide[DATA_W-1:0];
        pclamp_d = (p_wide != wide_t'(p_full));

        // First beat of a window ignores whatever the previous window left behind
        base     = m_first ? '0 : acc_q;
        s_raw    = wide_t'($signed(base)) + wide_t'($signed(prod_q));
        s_wide   = sat(s_raw, DATA_W);
        sclamp   = (s_wide != s_raw);
        acc_d    = s_wide[DATA_W-1:0];

        flag_d   = pclamp_q | sclamp | (!m_first & flag_q);
        res_d    = (m_relu && acc_d[DATA_W-1]) ? '0 : acc_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q    <= '0;
            pclamp_q  <= 1'b0;
            acc_q     <= '0;
            flag_q    <= 1'b0;
            res_q     <= '0;
            res_sat_q <= 1'b0;
        end else begin
            if (adv && beat) begin
                prod_q   <= prod_d;
                pclamp_q <= pclamp_d;
            end
            if (adv && m_vld) begin
                acc_q  <= acc_d;
                flag_q <= flag_d;
                if (m_last) begin
                    res_q     <= res_d;
                    res_sat_q <= flag_d;
                end
            end
        end
    end

    assign res     = res_q;
    assign res_sat = res_sat_q;
endmodule

// File: rtl/mac_vec.sv
// Multi-lane saturating MAC engine: window counter, handshake and output-valid control
// around LANES copies of mac_lane.
module mac_vec
    import mac_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_relu,
    mac_vec_if.slave         bus,
    output logic             busy
);
    logic             adv, beat, first, last, relu_eff;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] cnt_d, cnt_q;
    logic [LEN_W-1:0] len_d, len_q;
    logic             relu_d, relu_q;
    logic             m_vld_d, m_vld_q;
    logic             m_first_d, m_first_q;
    logic             m_last_d, m_last_q;
    logic             m_relu_d, m_relu_q;
    logic             out_valid_d, out_valid_q;
    logic [LANES-1:0][DATA_W-1:0] res_vec;
    logic [LANES-1:0]             sat_vec;

    always_comb begin
        adv      = !out_valid_q || bus.out_ready;
        beat     = bus.in_valid && adv;
        first    = (cnt_q == '0);
        len_eff  = first ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : len_q;
        relu_eff = first ? cfg_relu : relu_q;
        last     = (cnt_q == len_eff - LEN_W'(1));

        cnt_d     = cnt_q;
        len_d     = len_q;
        relu_d    = relu_q;
        m_vld_d   = m_vld_q;
        m_first_d = m_first_q;
        m_last_d  = m_last_q;
        m_relu_d  = m_relu_q;
        if (beat) begin
            cnt_d  = last ? '0 : cnt_q + LEN_W'(1);
            len_d  = len_eff;
            relu_d = relu_eff;
        end
        if (adv) begin
            m_vld_d   = beat;
            m_first_d = beat && first;
            m_last_d  = beat && last;
            m_relu_d  = relu_eff;
        end

        // A new result may land in the same edge the old one is taken
        out_valid_d = out_valid_q;
        if (adv && m_vld_q && m_last_q) out_valid_d = 1'b1;
        else if (bus.out_ready)         out_valid_d = 1'b0;

        busy = (cnt_q != '0) || m_vld_q || out_valid_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            len_q       <= '0;
            relu_q      <= 1'b0;
            m_vld_q     <= 1'b0;
            m_first_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_relu_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            relu_q      <= relu_d;
            m_vld_q     <= m_vld_d;
            m_first_q   <= m_first_d;
            m_last_q    <= m_last_d;
            m_relu_q    <= m_relu_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(.DATA_W(DATA_W)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .adv     (adv),
            .beat    (beat),
            .m_vld   (m_vld_q),
            .m_first (m_first_q),
            .m_last  (m_last_q),
            .m_relu  (m_relu_q),
            .x       (bus.in_x[l]),
            .f       (bus.in_f[l]),
            .res     (res_vec[l]),
            .res_sat (sat_vec[l])
        );
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = res_vec;
    assign bus.out_sat   = sat_vec;
endmodule
